// File: rtl/rob_commit_unit_pkg.sv
// Shared sizing, instruction-kind encodings and id helpers for the reorder buffer.
package rob_commit_unit_pkg;

  localparam int ROB_SIZE  = 8;
  localparam int ROB_ID_W  = 4;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam int DATA_W    = 32;
  localparam int CNT_W     = ROB_IDX_W + 1;

  // Id value one past the last entry marks an operand with no producer.
  localparam logic [ROB_ID_W-1:0] NON_DEPENDENT = ROB_ID_W'(ROB_SIZE);

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_JUMP   = 2'd3
  } rob_kind_e;

  // Per-entry payload; busy/ready live in separate vectors.
  typedef struct packed {
    rob_kind_e         kind;
    logic [4:0]        rd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pred_pc;
    logic [DATA_W-1:0] value;
    logic              jump;
    logic [DATA_W-1:0] pc_next;
  } rob_entry_t;

  function automatic logic id_valid(input logic [ROB_ID_W-1:0] id);
    return id < NON_DEPENDENT;
  endfunction

  function automatic logic [ROB_IDX_W-1:0] id_to_idx(input logic [ROB_ID_W-1:0] id);
    return ROB_IDX_W'(id);
  endfunction

  function automatic logic is_control(input rob_kind_e kind);
    return (kind == KIND_BRANCH) || (kind == KIND_JUMP);
  endfunction

  function automatic logic writes_rd(input rob_kind_e kind);
    return (kind == KIND_REG) || (kind == KIND_JUMP);
  endfunction

endpackage

// File: rtl/rob_commit_unit_query_fwd.sv
// Operand lookup for the dispatcher: CDB bypass first (RS over LSB), then stored result.
module rob_query_fwd
  import rob_commit_unit_pkg::*;
(
  input  logic [ROB_ID_W-1:0]               query_id_i,
  input  logic [ROB_SIZE-1:0]               busy_i,
  input  logic [ROB_SIZE-1:0]               ready_i,
  input  logic [ROB_SIZE-1:0][DATA_W-1:0]   value_i,
  input  logic                              rs_en_i,
  input  logic [ROB_ID_W-1:0]               rs_id_i,
  input  logic [DATA_W-1:0]                 rs_value_i,
  input  logic                              lsb_en_i,
  input  logic [ROB_ID_W-1:0]               lsb_id_i,
  input  logic [DATA_W-1:0]                 lsb_value_i,
  output logic                              ready_o,
  output logic [DATA_W-1:0]                 value_o
);

  logic [ROB_IDX_W-1:0] idx;

  assign idx = id_to_idx(query_id_i);

  // Resolve the operand: no producer, live broadcast, or value held in the entry.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ready_o = 1'b0;
    value_o = '0;
    if (query_id_i == NON_DEPENDENT) begin
      ready_o = 1'b1;
    end else if (rs_en_i && (rs_id_i == query_id_i)) begin
      ready_o = 1'b1;
      value_o = rs_value_i;
    end else if (lsb_en_i && (lsb_id_i == query_id_i)) begin
      ready_o = 1'b1;
      value_o = lsb_value_i;
    end else if (id_valid(query_id_i) && busy_i[idx] && ready_i[idx]) begin
      ready_o = 1'b1;
      value_o = value_i[idx];
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates in program order, captures CDB results, retires one
// entry per cycle and raises a one-cycle flush on a mispredicted control transfer.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                enable_from_dsp,
  input  logic [1:0]          kind_from_dsp,
  input  logic [4:0]          rd_from_dsp,
  input  logic [DATA_W-1:0]   pc_from_dsp,
  input  logic [DATA_W-1:0]   pred_pc_from_dsp,
  output logic [ROB_ID_W-1:0] rob_tail_id,
  output logic                full_rob,
  input  logic [ROB_ID_W-1:0] query_j_id,
  input  logic [ROB_ID_W-1:0] query_k_id,
  output logic                query_j_ready,
  output logic                query_k_ready,
  output logic [DATA_W-1:0]   query_j_value,
  output logic [DATA_W-1:0]   query_k_value,
  input  logic                enable_cdb_rs,
  input  logic [ROB_ID_W-1:0] cdb_rs_rob_id,
  input  logic [DATA_W-1:0]   cdb_rs_value,
  input  logic                cdb_rs_jump,
  input  logic [DATA_W-1:0]   cdb_rs_pc_next,
  input  logic                enable_cdb_lsb,
  input  logic [ROB_ID_W-1:0] cdb_lsb_rob_id,
  input  logic [DATA_W-1:0]   cdb_lsb_value,
  output logic                commit_reg_en,
  output logic [4:0]          commit_rd,
  output logic [DATA_W-1:0]   commit_value,
  output logic [ROB_ID_W-1:0] commit_rob_id,
  output logic                commit_store_en,
  output logic                br_update_en,
  output logic [DATA_W-1:0]   br_pc,
  output logic                br_taken,
  output logic                mispredict,
  output logic [DATA_W-1:0]   redirect_pc
);

  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(ROB_SIZE);
  localparam logic [CNT_W-1:0] COUNT_HIGH = CNT_W'(ROB_SIZE - 1);

  logic [ROB_SIZE-1:0]  busy_q, busy_d, ready_q, ready_d;
  logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  rob_entry_t                      entry_q [ROB_SIZE];
  rob_entry_t                      head_e;
  logic [ROB_SIZE-1:0][DATA_W-1:0] entry_value;

  logic                 rs_en, lsb_en, rs_hit, lsb_hit, lsb_write;
  logic [ROB_IDX_W-1:0] rs_idx, lsb_idx;
  logic                 do_alloc, do_commit, do_flush;

  logic                 commit_reg_en_q, commit_store_en_q, br_update_en_q;
  logic                 br_taken_q, mispredict_q;
  logic [4:0]           commit_rd_q;
  logic [DATA_W-1:0]    commit_value_q, br_pc_q, redirect_pc_q;
  logic [ROB_ID_W-1:0]  commit_rob_id_q;

  // Bus traffic arriving during the flush cycle belongs to squashed work.
  assign rs_en   = enable_cdb_rs  && !mispredict_q;
  assign lsb_en  = enable_cdb_lsb && !mispredict_q;
  assign rs_idx  = id_to_idx(cdb_rs_rob_id);
  assign lsb_idx = id_to_idx(cdb_lsb_rob_id);
  assign rs_hit  = rs_en  && id_valid(cdb_rs_rob_id)  && busy_q[rs_idx];
  assign lsb_hit = lsb_en && id_valid(cdb_lsb_rob_id) && busy_q[lsb_idx];
  // RS result wins when both buses name the same entry.
  assign lsb_write = lsb_hit && !(rs_hit && (cdb_rs_rob_id == cdb_lsb_rob_id));

  // Commit looks only at the registered ready bit, never at this cycle's CDB.
  assign head_e    = entry_q[head_q];
  assign do_commit = !mispredict_q && busy_q[head_q] && ready_q[head_q];
  assign do_flush  = do_commit && is_control(head_e.kind) && (head_e.pc_next != head_e.pred_pc);
  assign do_alloc  = enable_from_dsp && !mispredict_q && (count_q != COUNT_FULL);

  // Flatten stored results for the operand lookup.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) entry_value[i] = entry_q[i].value;
  end

  // Next pointers, occupancy and per-entry status for this edge.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_alloc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + 1'b1;
    end
    if (lsb_hit) ready_d[lsb_idx] = 1'b1;
    if (rs_hit)  ready_d[rs_idx]  = 1'b1;
    if (do_commit) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (do_alloc && !do_commit) count_d = count_q + 1'b1;
    if (!do_alloc && do_commit) count_d = count_q - 1'b1;
    if (do_flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state register; frozen while rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      // NOTE: sequential state uses non-blocking assignment so all flops sample the same pre-edge values.
      busy_q  <= busy_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload: written on allocation and on CDB capture.
  // NOTE: payload storage has no reset; busy/ready qualify every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (do_alloc) begin
        entry_q[tail_q].kind    <= rob_kind_e'(kind_from_dsp);
        entry_q[tail_q].rd      <= rd_from_dsp;
        entry_q[tail_q].pc      <= pc_from_dsp;
        entry_q[tail_q].pred_pc <= pred_pc_from_dsp;
      end
      if (lsb_write) entry_q[lsb_idx].value <= cdb_lsb_value;
      if (rs_hit) begin
        entry_q[rs_idx].value   <= cdb_rs_value;
        entry_q[rs_idx].jump    <= cdb_rs_jump;
        entry_q[rs_idx].pc_next <= cdb_rs_pc_next;
      end
    end
  end

  // Registered retirement pulses, predictor update and flush request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_reg_en_q   <= 1'b0;
      commit_store_en_q <= 1'b0;
      br_update_en_q    <= 1'b0;
      br_taken_q        <= 1'b0;
      mispredict_q      <= 1'b0;
      commit_rd_q       <= '0;
      commit_value_q    <= '0;
      commit_rob_id_q   <= '0;
      br_pc_q           <= '0;
      redirect_pc_q     <= '0;
    end else if (rdy) begin
      commit_reg_en_q   <= do_commit && writes_rd(head_e.kind) && (head_e.rd != 5'd0);
      commit_store_en_q <= do_commit && (head_e.kind == KIND_STORE);
      br_update_en_q    <= do_commit && is_control(head_e.kind);
      mispredict_q      <= do_flush;
      if (do_commit) begin
        commit_rd_q     <= head_e.rd;
        commit_value_q  <= head_e.value;
        commit_rob_id_q <= ROB_ID_W'(head_q);
      end
      if (do_commit && is_control(head_e.kind)) begin
        br_pc_q    <= head_e.pc;
        br_taken_q <= head_e.jump;
      end
      if (do_flush) redirect_pc_q <= head_e.pc_next;
    end
  end

  rob_query_fwd u_query_j (
    .query_id_i  (query_j_id),
    .busy_i      (busy_q),
    .ready_i     (ready_q),
    .value_i     (entry_value),
    .rs_en_i     (rs_en),
    .rs_id_i     (cdb_rs_rob_id),
    .rs_value_i  (cdb_rs_value),
    .lsb_en_i    (lsb_en),
    .lsb_id_i    (cdb_lsb_rob_id),
    .lsb_value_i (cdb_lsb_value),
    .ready_o     (query_j_ready),
    .value_o     (query_j_value)
  );

  rob_query_fwd u_query_k (
    .query_id_i  (query_k_id),
    .busy_i      (busy_q),
    .ready_i     (ready_q),
    .value_i     (entry_value),
    .rs_en_i     (rs_en),
    .rs_id_i     (cdb_rs_rob_id),
    .rs_value_i  (cdb_rs_value),
    .lsb_en_i    (lsb_en),
    .lsb_id_i    (cdb_lsb_rob_id),
    .lsb_value_i (cdb_lsb_value),
    .ready_o     (query_k_ready),
    .value_o     (query_k_value)
  );

  // One slot of margin covers a dispatch already in flight when full_rob rises.
  assign full_rob        = (count_q >= COUNT_HIGH);
  assign rob_tail_id     = ROB_ID_W'(tail_q);
  assign commit_reg_en   = commit_reg_en_q;
  assign commit_rd       = commit_rd_q;
  assign commit_value    = commit_value_q;
  assign commit_rob_id   = commit_rob_id_q;
  assign commit_store_en = commit_store_en_q;
  assign br_update_en    = br_update_en_q;
  assign br_pc           = br_pc_q;
  assign br_taken        = br_taken_q;
  assign mispredict      = mispredict_q;
  assign redirect_pc     = redirect_pc_q;

  // Dispatching into a completely full buffer is a protocol violation.
  dispatch_when_full_a : assert property (@(posedge clk) disable iff (!rst)
    !(rdy && enable_from_dsp && !mispredict_q && (count_q == COUNT_FULL)));

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit with a queue-based reference model.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        enable_from_dsp;
  logic [1:0]  kind_from_dsp;
  logic [4:0]  rd_from_dsp;
  logic [31:0] pc_from_dsp, pred_pc_from_dsp;
  logic [3:0]  rob_tail_id;
  logic        full_rob;
  logic [3:0]  query_j_id, query_k_id;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic        enable_cdb_rs;
  logic [3:0]  cdb_rs_rob_id;
  logic [31:0] cdb_rs_value;
  logic        cdb_rs_jump;
  logic [31:0] cdb_rs_pc_next;
  logic        enable_cdb_lsb;
  logic [3:0]  cdb_lsb_rob_id;
  logic [31:0] cdb_lsb_value;
  logic        commit_reg_en;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_rob_id;
  logic        commit_store_en, br_update_en, br_taken, mispredict;
  logic [31:0] br_pc, redirect_pc;

  rob_commit_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enable_from_dsp(enable_from_dsp), .kind_from_dsp(kind_from_dsp),
    .rd_from_dsp(rd_from_dsp), .pc_from_dsp(pc_from_dsp), .pred_pc_from_dsp(pred_pc_from_dsp),
    .rob_tail_id(rob_tail_id), .full_rob(full_rob),
    .query_j_id(query_j_id), .query_k_id(query_k_id),
    .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
    .query_j_value(query_j_value), .query_k_value(query_k_value),
    .enable_cdb_rs(enable_cdb_rs), .cdb_rs_rob_id(cdb_rs_rob_id), .cdb_rs_value(cdb_rs_value),
    .cdb_rs_jump(cdb_rs_jump), .cdb_rs_pc_next(cdb_rs_pc_next),
    .enable_cdb_lsb(enable_cdb_lsb), .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
    .commit_reg_en(commit_reg_en), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_id(commit_rob_id), .commit_store_en(commit_store_en),
    .br_update_en(br_update_en), .br_pc(br_pc), .br_taken(br_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Program-order queue of live ids; kinds: 0 REG, 1 STORE, 2 BRANCH, 3 JUMP.
  int          order[$];
  int          m_tail = 0;
  bit          mpend  = 0;
  int          m_kind [8];
  int          m_rd   [8];
  logic [31:0] m_pc [8], m_pred [8], m_val [8], m_next [8];
  bit          m_jump [8], m_ready [8];
  bit          e_reg_en = 0, e_store_en = 0, e_br_en = 0, e_mis = 0, e_br_taken = 0;
  logic [31:0] e_rd = 0, e_val = 0, e_id = 0, e_br_pc = 0, e_redirect = 0;

  function automatic bit live(input int id);
    foreach (order[i]) if (order[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic q_model(input logic [3:0] id, output bit r, output logic [31:0] v);
    r = 1'b0;
    v = 32'h0;
    if (id == 4'd8) r = 1'b1;
    else if (!mpend && enable_cdb_rs && cdb_rs_rob_id == id) begin r = 1'b1; v = cdb_rs_value; end
    else if (!mpend && enable_cdb_lsb && cdb_lsb_rob_id == id) begin r = 1'b1; v = cdb_lsb_value; end
    else if (id < 4'd8 && live(int'(id)) && m_ready[id]) begin r = 1'b1; v = m_val[id]; end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      order.delete(); m_tail = 0; mpend = 0;
      e_reg_en = 0; e_store_en = 0; e_br_en = 0; e_mis = 0; e_br_taken = 0;
      e_rd = 0; e_val = 0; e_id = 0; e_br_pc = 0; e_redirect = 0;
    end else if (rdy) begin
      if (mpend) begin
        mpend = 0; e_mis = 0; e_reg_en = 0; e_store_en = 0; e_br_en = 0;
      end else begin
        bit commit, mis;
        int h, k;
        commit = (order.size() > 0) && m_ready[order[0]];
        h = commit ? order[0] : 0;
        k = m_kind[h];
        e_reg_en   = commit && (k == 0 || k == 3) && (m_rd[h] != 0);
        e_store_en = commit && (k == 1);
        e_br_en    = commit && (k >= 2);
        if (commit) begin e_rd = m_rd[h]; e_val = m_val[h]; e_id = h; end
        if (commit && k >= 2) begin e_br_pc = m_pc[h]; e_br_taken = m_jump[h]; end
        mis   = commit && (k >= 2) && (m_next[h] != m_pred[h]);
        e_mis = mis;
        if (mis) e_redirect = m_next[h];
        if (enable_cdb_lsb && cdb_lsb_rob_id < 8 && live(int'(cdb_lsb_rob_id))) begin
          m_ready[cdb_lsb_rob_id] = 1; m_val[cdb_lsb_rob_id] = cdb_lsb_value;
        end
        if (enable_cdb_rs && cdb_rs_rob_id < 8 && live(int'(cdb_rs_rob_id))) begin
          m_ready[cdb_rs_rob_id] = 1; m_val[cdb_rs_rob_id] = cdb_rs_value;
          m_jump[cdb_rs_rob_id] = cdb_rs_jump; m_next[cdb_rs_rob_id] = cdb_rs_pc_next;
        end
        if (enable_from_dsp && order.size() < 8) begin
          order.push_back(m_tail);
          m_kind[m_tail] = int'(kind_from_dsp); m_rd[m_tail] = int'(rd_from_dsp);
          m_pc[m_tail] = pc_from_dsp; m_pred[m_tail] = pred_pc_from_dsp;
          m_ready[m_tail] = 0;
          m_tail = (m_tail + 1) % 8;
        end
        if (commit) void'(order.pop_front());
        if (mis) begin order.delete(); m_tail = 0; mpend = 1; end
      end
    end
  end

  bit          qr;
  logic [31:0] qv;

  always @(negedge clk) begin
    if (rst) begin
      check("tail_id", rob_tail_id, m_tail);
      check("full_rob", full_rob, order.size() >= 7);
      check("commit_reg_en", commit_reg_en, e_reg_en);
      check("commit_store_en", commit_store_en, e_store_en);
      check("br_update_en", br_update_en, e_br_en);
      check("mispredict", mispredict, e_mis);
      if (e_reg_en) begin
        check("commit_rd", commit_rd, e_rd);
        check("commit_value", commit_value, e_val);
      end
      if (e_reg_en || e_store_en || e_br_en) check("commit_rob_id", commit_rob_id, e_id);
      if (e_br_en) begin
        check("br_pc", br_pc, e_br_pc);
        check("br_taken", br_taken, e_br_taken);
      end
      if (e_mis) check("redirect_pc", redirect_pc, e_redirect);
      q_model(query_j_id, qr, qv);
      check("query_j_ready", query_j_ready, qr);
      if (qr) check("query_j_value", query_j_value, qv);
      q_model(query_k_id, qr, qv);
      check("query_k_ready", query_k_ready, qr);
      if (qr) check("query_k_value", query_k_value, qv);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] pred);
    enable_from_dsp = 1; kind_from_dsp = k; rd_from_dsp = rd;
    pc_from_dsp = pc; pred_pc_from_dsp = pred;
    cyc();
    enable_from_dsp = 0;
  endtask

  task automatic rs(input logic [3:0] id, input logic [31:0] val, input logic j, input logic [31:0] nx);
    enable_cdb_rs = 1; cdb_rs_rob_id = id; cdb_rs_value = val; cdb_rs_jump = j; cdb_rs_pc_next = nx;
    cyc();
    enable_cdb_rs = 0;
  endtask

  task automatic lsb(input logic [3:0] id, input logic [31:0] val);
    enable_cdb_lsb = 1; cdb_lsb_rob_id = id; cdb_lsb_value = val;
    cyc();
    enable_cdb_lsb = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 0; rdy = 1;
    enable_from_dsp = 0; kind_from_dsp = 0; rd_from_dsp = 0; pc_from_dsp = 0; pred_pc_from_dsp = 0;
    query_j_id = 4'd8; query_k_id = 4'd8;
    enable_cdb_rs = 0; cdb_rs_rob_id = 0; cdb_rs_value = 0; cdb_rs_jump = 0; cdb_rs_pc_next = 0;
    enable_cdb_lsb = 0; cdb_lsb_rob_id = 0; cdb_lsb_value = 0;
    cyc(); cyc();
    @(negedge clk);
    check("rst_tail_id", rob_tail_id, 0);
    check("rst_full", full_rob, 0);
    check("rst_reg_en", commit_reg_en, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_redirect", redirect_pc, 0);
    check("nondep_ready", query_j_ready, 1);
    check("nondep_value", query_j_value, 0);
    cyc();
    rst = 1;

    // 1: reset mid-operation
    disp(0, 1, 32'h10, 32'h14);
    disp(0, 2, 32'h14, 32'h18);
    disp(0, 3, 32'h18, 32'h1c);
    @(negedge clk);
    check("t1_tail_before", rob_tail_id, 3);
    cyc();
    rst = 0;
    #1;
    check("t1_async_tail", rob_tail_id, 0);
    check("t1_async_full", full_rob, 0);
    check("t1_async_reg_en", commit_reg_en, 0);
    check("t1_async_store_en", commit_store_en, 0);
    check("t1_async_br_en", br_update_en, 0);
    check("t1_async_commit_value", commit_value, 0);
    cyc();
    rst = 1;
    @(negedge clk);
    check("t1_after_tail", rob_tail_id, 0);

    // 2: in-order commit with out-of-order results
    disp(0, 5, 32'h200, 32'h204);
    disp(0, 6, 32'h204, 32'h208);
    enable_cdb_rs = 1; cdb_rs_rob_id = 1; cdb_rs_value = 32'h22; cdb_rs_jump = 0; cdb_rs_pc_next = 0;
    query_j_id = 1;
    @(negedge clk);
    check("t2_bypass_ready", query_j_ready, 1);
    check("t2_bypass_value", query_j_value, 32'h22);
    cyc();
    cdb_rs_rob_id = 0; cdb_rs_value = 32'h11; query_j_id = 4'd8;
    cyc();
    enable_cdb_rs = 0;
    @(negedge clk);
    check("t2_no_early_commit", commit_reg_en, 0);
    cyc();
    @(negedge clk);
    check("t2_c0_en", commit_reg_en, 1);
    check("t2_c0_rd", commit_rd, 5);
    check("t2_c0_val", commit_value, 32'h11);
    check("t2_c0_id", commit_rob_id, 0);
    cyc();
    @(negedge clk);
    check("t2_c1_rd", commit_rd, 6);
    check("t2_c1_val", commit_value, 32'h22);
    check("t2_c1_id", commit_rob_id, 1);
    cyc();
    @(negedge clk);
    check("t2_idle_en", commit_reg_en, 0);

    // 3: fill to full and wrap
    for (int i = 0; i < 7; i++) begin
      disp(0, 5'(10 + i), 32'h300 + 32'(4 * i), 32'h304 + 32'(4 * i));
      if (i == 5) begin
        @(negedge clk);
        check("t3_tail_wrap", rob_tail_id, 0);
      end
    end
    @(negedge clk);
    check("t3_full", full_rob, 1);
    check("t3_tail", rob_tail_id, 1);
    for (int i = 0; i < 7; i++) rs(4'((2 + i) % 8), 32'h100 + 32'((2 + i) % 8), 0, 0);
    @(negedge clk);
    check("t3_c7_id", commit_rob_id, 7);
    check("t3_c7_val", commit_value, 32'h107);
    cyc();
    @(negedge clk);
    check("t3_c0_id", commit_rob_id, 0);
    check("t3_c0_val", commit_value, 32'h100);
    check("t3_c0_rd", commit_rd, 16);
    cyc();
    @(negedge clk);
    check("t3_drained_full", full_rob, 0);

    // 4: mispredicted branch flushes younger entries
    disp(2, 0, 32'h100, 32'h104);
    disp(0, 7, 32'h104, 32'h108);
    disp(0, 8, 32'h108, 32'h10c);
    rs(2, 32'h55, 0, 0);
    rs(1, 32'h0, 1, 32'h140);
    @(negedge clk);
    check("t4_pre_mis", mispredict, 0);
    cyc();
    enable_from_dsp = 1; kind_from_dsp = 0; rd_from_dsp = 9; pc_from_dsp = 32'h900; pred_pc_from_dsp = 32'h904;
    enable_cdb_rs = 1; cdb_rs_rob_id = 3; cdb_rs_value = 32'h66; cdb_rs_jump = 0; cdb_rs_pc_next = 0;
    @(negedge clk);
    check("t4_br_en", br_update_en, 1);
    check("t4_br_pc", br_pc, 32'h100);
    check("t4_br_taken", br_taken, 1);
    check("t4_mis", mispredict, 1);
    check("t4_redirect", redirect_pc, 32'h140);
    check("t4_tail", rob_tail_id, 0);
    check("t4_reg_en", commit_reg_en, 0);
    cyc();
    enable_from_dsp = 0; enable_cdb_rs = 0;
    @(negedge clk);
    check("t4_mis_drop", mispredict, 0);
    check("t4_tail_held", rob_tail_id, 0);
    cyc(); cyc();
    @(negedge clk);
    check("t4_no_young_commit", commit_reg_en, 0);

    // 5: simultaneous bus hits, bypass, dispatch with commit
    for (int i = 0; i < 7; i++) disp(0, 5'(20 + i), 32'h400 + 32'(4 * i), 32'h404 + 32'(4 * i));
    enable_cdb_rs = 1;  cdb_rs_rob_id = 2;  cdb_rs_value = 32'hAAAA; cdb_rs_jump = 0; cdb_rs_pc_next = 0;
    enable_cdb_lsb = 1; cdb_lsb_rob_id = 2; cdb_lsb_value = 32'hBBBB;
    cyc();
    enable_cdb_rs = 0;
    cdb_lsb_rob_id = 3; cdb_lsb_value = 32'h3333;
    query_j_id = 3; query_k_id = 2;
    @(negedge clk);
    check("t5_bypass_ready", query_j_ready, 1);
    check("t5_bypass_value", query_j_value, 32'h3333);
    check("t5_rs_wins_ready", query_k_ready, 1);
    check("t5_rs_wins_value", query_k_value, 32'hAAAA);
    cyc();
    enable_cdb_lsb = 0; query_j_id = 4'd8; query_k_id = 4'd8;
    rs(0, 32'h1000, 0, 0);
    disp(0, 27, 32'h500, 32'h504);
    @(negedge clk);
    check("t5_count_kept_full", full_rob, 1);
    check("t5_tail", rob_tail_id, 0);
    check("t5_commit_id", commit_rob_id, 0);
    check("t5_commit_val", commit_value, 32'h1000);
    rs(1, 32'h2001, 0, 0);
    rs(4, 32'h2004, 0, 0);
    rs(5, 32'h2005, 0, 0);
    rs(6, 32'h2006, 0, 0);
    rs(7, 32'h2007, 0, 0);
    repeat (10) cyc();

    // 6: store release and x0 destination
    disp(1, 0, 32'h600, 32'h604);
    disp(0, 0, 32'h604, 32'h608);
    disp(0, 9, 32'h608, 32'h60c);
    lsb(0, 32'hDEAD);
    enable_cdb_rs = 1; cdb_rs_rob_id = 1; cdb_rs_value = 32'h77; cdb_rs_jump = 0; cdb_rs_pc_next = 0;
    cyc();
    cdb_rs_rob_id = 2; cdb_rs_value = 32'h99;
    @(negedge clk);
    check("t6_store_en", commit_store_en, 1);
    check("t6_store_no_reg", commit_reg_en, 0);
    check("t6_store_id", commit_rob_id, 0);
    cyc();
    enable_cdb_rs = 0;
    @(negedge clk);
    check("t6_x0_no_reg", commit_reg_en, 0);
    check("t6_x0_no_store", commit_store_en, 0);
    cyc();
    @(negedge clk);
    check("t6_after_x0_en", commit_reg_en, 1);
    check("t6_after_x0_rd", commit_rd, 9);
    check("t6_after_x0_val", commit_value, 32'h99);
    check("t6_after_x0_id", commit_rob_id, 2);

    // 7: rdy low freezes state and registered outputs
    disp(0, 3, 32'h700, 32'h704);
    rs(3, 32'h5, 0, 0);
    cyc();
    @(negedge clk);
    check("t7_commit", commit_reg_en, 1);
    check("t7_val", commit_value, 32'h5);
    rdy = 0;
    enable_from_dsp = 1; kind_from_dsp = 0; rd_from_dsp = 4; pc_from_dsp = 32'h710; pred_pc_from_dsp = 32'h714;
    cyc(); cyc();
    @(negedge clk);
    check("t7_hold_pulse", commit_reg_en, 1);
    check("t7_hold_tail", rob_tail_id, 4);
    rdy = 1;
    enable_from_dsp = 0;
    cyc();
    @(negedge clk);
    check("t7_pulse_ends", commit_reg_en, 0);
    check("t7_tail_after", rob_tail_id, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer: the consuming end of the CDB broadcast driven by the reservation station and the LSB.
- Allocates an entry per dispatched instruction and captures results from `cdb_rs_*` / `cdb_lsb_*`.
- Retires entries in program order, one per cycle, to the register file and the LSB.
- Detects control-flow mispredicts at commit and drives the global `mispredict` flush with a redirect PC.

Parameters:
- ROB_SIZE, 8: number of entries; power of two.
- ROB_ID_W, 4: id width; ids 0..ROB_SIZE-1 are valid, value ROB_SIZE is NON_DEPENDENT.
- DATA_W, 32: data and address width.

Ports:
- clk  in  1  clock, posedge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global stall; state holds while low.
- enable_from_dsp  in  1  allocate one entry this cycle.
- kind_from_dsp  in  2  0=REG (writes rd), 1=STORE, 2=BRANCH (no rd), 3=JUMP (writes rd, control).
- rd_from_dsp  in  5  destination register.
- pc_from_dsp  in  DATA_W  instruction PC.
- pred_pc_from_dsp  in  DATA_W  predicted next PC.
- rob_tail_id  out  ROB_ID_W  id the next allocation receives.
- full_rob  out  1  high when count >= ROB_SIZE-1.
- query_j_id, query_k_id  in  ROB_ID_W  dispatcher operand lookups.
- query_j_ready, query_k_ready  out  1  value available.
- query_j_value, query_k_value  out  DATA_W  forwarded value.
- enable_cdb_rs  in  1  RS broadcast valid.
- cdb_rs_rob_id  in  ROB_ID_W  RS broadcast id.
- cdb_rs_value  in  DATA_W  RS result.
- cdb_rs_jump  in  1  actual taken.
- cdb_rs_pc_next  in  DATA_W  actual next PC.
- enable_cdb_lsb  in  1  LSB broadcast valid (load data or store-address done).
- cdb_lsb_rob_id  in  ROB_ID_W  LSB broadcast id.
- cdb_lsb_value  in  DATA_W  LSB value.
- commit_reg_en  out  1  register writeback pulse.
- commit_rd  out  5  destination register.
- commit_value  out  DATA_W  writeback value.
- commit_rob_id  out  ROB_ID_W  id of the retired entry.
- commit_store_en  out  1  release head store in LSB.
- br_update_en  out  1  predictor update pulse.
- br_pc  out  DATA_W  branch PC for predictor update.
- br_taken  out  1  actual direction for predictor update.
- mispredict  out  1  global flush.
- redirect_pc  out  DATA_W  fetch restart address.

Behaviour:
- Reset (rst low, asynchronous): head=tail=count=0; all busy/ready cleared; every registered output 0; rob_tail_id=0; full_rob=0.
- rdy low: no state change. Registered outputs hold their values.
- Allocation, at edge with enable_from_dsp:
  - entry[tail] takes busy=1, ready=0, kind, rd, pc, pred_pc.
  - tail wraps ROB_SIZE-1 -> 0.
  - count+1, unless a commit occurs the same edge, in which case count is unchanged.
- Dispatch with count==ROB_SIZE is a protocol violation: ignored, simulation assertion fires.
- CDB capture: for each valid bus whose id < ROB_SIZE and whose entry is busy, the entry takes ready=1 and value. RS capture also takes jump and pc_next.
  - If both buses carry the same id, RS wins.
  - Ids equal to NON_DEPENDENT, and ids of non-busy entries, are ignored.
- Query: purely combinational.
  - ready = (entry busy && ready) || matching valid CDB this cycle. CDB takes priority, RS over LSB.
  - NON_DEPENDENT query id returns ready=1, value=0.
- Commit, at most one per edge: the head is retired when busy && ready, using the registered ready bit only. A CDB result therefore commits no earlier than the following edge.
  - All commit outputs are registered one-cycle pulses: commit_rob_id = head id.
  - REG/JUMP: commit_reg_en=1 unless rd==0.
  - STORE: commit_store_en=1.
  - BRANCH/JUMP: br_update_en=1, br_pc=pc, br_taken=jump.
  - Head advances with wrap; busy cleared.
- Mispredict: a committed BRANCH/JUMP with pc_next != pred_pc triggers it.
  - At the same edge: the entry still retires (rd written for JUMP), mispredict<=1, redirect_pc<=pc_next, and all entries are cleared (head=tail=count=0).
  - The next cycle mispredict=1. During it, dispatch and CDB inputs are ignored and no commit occurs.
  - The following edge: mispredict<=0.
- full_rob keeps a one-slot margin for a dispatch already in flight.

Decomposition:
- Shared define package: ROB_SIZE, ROB_ID_W, NON_DEPENDENT, KIND_REG/STORE/BRANCH/JUMP encodings.
- One sub-module is natural: rob_query_fwd, the combinational operand lookup and CDB bypass, instantiated twice (j and k).

Test Plan:
1. Reset mid-operation: dispatch 3 entries, drop rst for 1 cycle -> all outputs 0, rob_tail_id=0, full_rob=0.
2. In-order commit: dispatch REG rd=5 (id0) and REG rd=6 (id1); CDB_RS id1=0x22 then id0=0x11 -> commits id0 (rd5=0x11) before id1 (rd6=0x22), one edge apart.
3. Full/wrap: fill 7 entries -> full_rob=1 at count=7; retire and refill across the wrap -> tail wraps 7->0, ids stay in order.
4. Mispredict: BRANCH pc=0x100, pred=0x104; CDB_RS jump=1 pc_next=0x140 -> br_update_en with br_taken=1; mispredict=1 for exactly one cycle with redirect_pc=0x140; count=0; younger entries never commit.
5. Simultaneous events: CDB_RS and CDB_LSB both hit id2 -> RS value captured. Query of id3 the same cycle its CDB fires -> ready=1 with bus value. Dispatch plus commit on one edge -> count unchanged.
6. Store and x0: STORE readied by CDB_LSB -> commit_store_en=1, commit_reg_en=0. REG rd=0 -> no commit_reg_en, head still advances.
